// File: rtl/vote_tally_ctrl.sv
// vote_tally_ctrl: session FSM, round-robin vote tally, winner resolution and
// multiplexed 4-digit display feed for the 4-candidate voting machine.
module vote_tally_ctrl #(
    parameter int CNT_W    = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             open_i,
    input  logic             close_i,
    input  logic             clear_i,
    input  logic [3:0]       vote,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3,
    output logic [3:0]       pending_o,
    output logic [1:0]       winner,
    output logic             winner_valid,
    output logic             tie,
    output logic [3:0]       code,
    output logic [3:0]       dig_en
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OPEN   = 2'b01,
        CLOSED = 2'b10
    } state_t;

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCAN_DIV / 2);
    localparam bit               BLINK_EN = (SCAN_DIV > 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt      [4];
    logic [CNT_W-1:0] cnt_next [4];
    logic [3:0]       pending;
    logic [3:0]       pending_next;
    logic [1:0]       rr;
    logic [1:0]       rr_next;

    logic             grant_found;
    logic [1:0]       grant_idx;
    logic [1:0]       cand;

    logic [1:0]       win_next;
    logic             tie_next;
    logic [CNT_W-1:0] best;
    logic [2:0]       n_best;

    logic [1:0]       scan;
    logic [1:0]       scan_next;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_next;
    logic [3:0]       code_next;

    // Round-robin search over pending requests, starting at rr and wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = rr + 2'(k);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Next session state, tallies, pending latches and arbitration pointer.
    always_comb begin
        state_next   = state;
        pending_next = pending;
        rr_next      = rr;
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_next[2'(i)] = cnt[2'(i)];
        end
        case (state)
            IDLE: begin
                if (clear_i) begin
                    for (int unsigned i = 0; i < 4; i++) begin
                        cnt_next[2'(i)] = '0;
                    end
                end else if (open_i) begin
                    state_next = OPEN;
                end
            end
            OPEN: begin
                if (grant_found) begin
                    if (cnt[grant_idx] != CNT_MAX) begin
                        cnt_next[grant_idx] = cnt[grant_idx] + 1'b1;
                    end
                    pending_next[grant_idx] = 1'b0;
                    rr_next                 = grant_idx + 2'd1;
                end
                // A fresh request on the bit just granted re-arms it.
                pending_next = pending_next | vote;
                if (close_i) begin
                    state_next   = CLOSED;
                    pending_next = '0;
                end
            end
            CLOSED: begin
                if (clear_i) begin
                    state_next = IDLE;
                    for (int unsigned i = 0; i < 4; i++) begin
                        cnt_next[2'(i)] = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Winner over the post-update tallies; strict compare keeps the lowest index.
    always_comb begin
        win_next = '0;
        best     = cnt_next[0];
        n_best   = '0;
        for (int unsigned i = 1; i < 4; i++) begin
            if (cnt_next[2'(i)] > best) begin
                best     = cnt_next[2'(i)];
                win_next = 2'(i);
            end
        end
        for (int unsigned i = 0; i < 4; i++) begin
            if (cnt_next[2'(i)] == best) begin
                n_best = n_best + 3'd1;
            end
        end
        tie_next = (n_best >= 3'd2);
    end

    // Digit scan timing and the code nibble for the digit being entered.
    always_comb begin
        if (div == DIV_LAST) begin
            div_next  = '0;
            scan_next = scan + 2'd1;
        end else begin
            div_next  = div + 1'b1;
            scan_next = scan;
        end
        code_next = cnt_next[scan_next][3:0];
        if (BLINK_EN && (state_next == CLOSED) && (scan_next == win_next) &&
            (div_next < DIV_HALF)) begin
            code_next = 4'hF;
        end
    end

    // Session FSM with tallies, pending requests and registered winner outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            pending      <= '0;
            rr           <= '0;
            winner       <= '0;
            winner_valid <= 1'b0;
            tie          <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[2'(i)] <= '0;
            end
        end else begin
            state        <= state_next;
            pending      <= pending_next;
            rr           <= rr_next;
            winner       <= (state_next == CLOSED) ? win_next : 2'd0;
            winner_valid <= (state_next == CLOSED);
            tie          <= (state_next == CLOSED) && tie_next;
            for (int unsigned i = 0; i < 4; i++) begin
                cnt[2'(i)] <= cnt_next[2'(i)];
            end
        end
    end

    // Display scan registers; code is built from next-cycle values to stay aligned with dig_en.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan   <= '0;
            div    <= '0;
            dig_en <= 4'b0001;
            code   <= '0;
        end else begin
            scan   <= scan_next;
            div    <= div_next;
            dig_en <= 4'b0001 << scan_next;
            code   <= code_next;
        end
    end

    assign state_o   = state;
    assign cnt0      = cnt[0];
    assign cnt1      = cnt[1];
    assign cnt2      = cnt[2];
    assign cnt3      = cnt[3];
    assign pending_o = pending;

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Bench for vote_tally_ctrl: behavioural model compared every cycle, directed
// scenarios with literal expectations, then a randomized run.
module tb_vote_tally_ctrl;

    localparam int CNT_W    = 8;
    localparam int SCAN_DIV = 4;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic             clk     = 1'b0;
    logic             reset   = 1'b1;
    logic             open_i  = 1'b0;
    logic             close_i = 1'b0;
    logic             clear_i = 1'b0;
    logic [3:0]       vote    = 4'b0000;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] cnt0, cnt1, cnt2, cnt3;
    logic [3:0]       pending_o;
    logic [1:0]       winner;
    logic             winner_valid;
    logic             tie;
    logic [3:0]       code;
    logic [3:0]       dig_en;

    vote_tally_ctrl #(.CNT_W(CNT_W), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .reset(reset), .open_i(open_i), .close_i(close_i),
        .clear_i(clear_i), .vote(vote), .state_o(state_o),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
        .pending_o(pending_o), .winner(winner), .winner_valid(winner_valid),
        .tie(tie), .code(code), .dig_en(dig_en)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // state: 0 idle, 1 open, 2 closed
    int m_state;
    int m_cnt [4];
    bit m_pend [4];
    int m_rr;
    int m_scan;
    int m_div;
    bit m_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_state = 0;
            m_rr    = 0;
            m_scan  = 0;
            m_div   = 0;
            for (int i = 0; i < 4; i++) begin
                m_cnt[i]  = 0;
                m_pend[i] = 1'b0;
            end
            m_ok = 1'b1;
        end else if (m_ok) begin
            case (m_state)
                0: begin
                    if (clear_i) begin
                        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                    end else if (open_i) begin
                        m_state = 1;
                    end
                end
                1: begin
                    int g;
                    g = -1;
                    for (int k = 0; k < 4; k++) begin
                        if (g < 0 && m_pend[(m_rr + k) % 4]) g = (m_rr + k) % 4;
                    end
                    if (g >= 0) begin
                        if (m_cnt[g] < MAXC) m_cnt[g] = m_cnt[g] + 1;
                        m_pend[g] = 1'b0;
                        m_rr = (g + 1) % 4;
                    end
                    for (int i = 0; i < 4; i++) begin
                        if (vote[i]) m_pend[i] = 1'b1;
                    end
                    if (close_i) begin
                        m_state = 2;
                        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
                    end
                end
                default: begin
                    if (clear_i) begin
                        m_state = 0;
                        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                    end
                end
            endcase
            m_div = m_div + 1;
            if (m_div == SCAN_DIV) begin
                m_div  = 0;
                m_scan = (m_scan + 1) % 4;
            end
        end
    end

    function automatic int exp_win();
        int w = 0;
        for (int i = 1; i < 4; i++) if (m_cnt[i] > m_cnt[w]) w = i;
        return w;
    endfunction

    function automatic int exp_tie();
        int n = 0;
        int w = exp_win();
        for (int i = 0; i < 4; i++) if (m_cnt[i] == m_cnt[w]) n++;
        return (n >= 2) ? 1 : 0;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_ok) begin
            int pv;
            int ew;
            int ec;
            pv = 0;
            for (int i = 0; i < 4; i++) if (m_pend[i]) pv = pv | (1 << i);
            ew = (m_state == 2) ? exp_win() : 0;
            ec = m_cnt[m_scan] % 16;
            if (m_state == 2 && SCAN_DIV > 1 && m_scan == ew && m_div < SCAN_DIV / 2) ec = 15;
            chk("m_state",   32'(state_o),      m_state);
            chk("m_cnt0",    32'(cnt0),         m_cnt[0]);
            chk("m_cnt1",    32'(cnt1),         m_cnt[1]);
            chk("m_cnt2",    32'(cnt2),         m_cnt[2]);
            chk("m_cnt3",    32'(cnt3),         m_cnt[3]);
            chk("m_pending", 32'(pending_o),    pv);
            chk("m_winner",  32'(winner),       ew);
            chk("m_valid",   32'(winner_valid), (m_state == 2) ? 1 : 0);
            chk("m_tie",     32'(tie),          (m_state == 2) ? exp_tie() : 0);
            chk("m_dig_en",  32'(dig_en),       1 << m_scan);
            chk("m_code",    32'(code),         ec);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
    endtask

    task automatic open_sess();
        open_i = 1'b1;
        cyc(1);
        open_i = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        vote = v;
        cyc(1);
        vote = 4'b0000;
        cyc(5);
    endtask

    task automatic wait_dig(input logic [3:0] want, input string name);
        int n = 0;
        while (dig_en !== want && n < 64) begin
            cyc(1);
            n++;
        end
        chk(name, 32'(dig_en), int'(want));
    endtask

    function automatic int dut_cnt(input int i);
        case (i)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            2:       return int'(cnt2);
            default: return int'(cnt3);
        endcase
    endfunction

    initial begin
        int scan_exp [4];
        scan_exp = '{3, 7, 10, 1};

        // single vote latency
        cyc(2);
        reset = 1'b0;
        chk("rst_dig_en", 32'(dig_en), 1);
        chk("rst_state", 32'(state_o), 0);
        open_sess();
        chk("t1_state", 32'(state_o), 1);
        vote = 4'b0100;
        cyc(1);
        vote = 4'b0000;
        chk("t1_pend", 32'(pending_o), 4);
        chk("t1_cnt2_early", 32'(cnt2), 0);
        cyc(1);
        chk("t1_cnt2", 32'(cnt2), 1);
        chk("t1_pend_clr", 32'(pending_o), 0);

        // round-robin order from rr=0
        do_reset();
        open_sess();
        vote = 4'b1111;
        cyc(1);
        vote = 4'b0000;
        chk("t2_pend", 32'(pending_o), 15);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            chk("t2_granted", 32'(dut_cnt(k - 1)), 1);
            if (k < 4) chk("t2_not_yet", 32'(dut_cnt(k)), 0);
        end
        chk("t2_pend_end", 32'(pending_o), 0);
        vote = 4'b1001;
        cyc(1);
        vote = 4'b0000;
        cyc(1);
        chk("t2_rr_cnt0", 32'(cnt0), 2);
        chk("t2_rr_cnt3", 32'(cnt3), 1);

        // saturation
        do_reset();
        open_sess();
        vote = 4'b0010;
        cyc(300);
        vote = 4'b0000;
        cyc(3);
        chk("t3_sat", 32'(cnt1), 255);
        chk("t3_cnt0", 32'(cnt0), 0);
        chk("t3_cnt3", 32'(cnt3), 0);

        // grant in the close cycle
        do_reset();
        open_sess();
        vote = 4'b0011;
        cyc(1);
        vote = 4'b0000;
        close_i = 1'b1;
        cyc(1);
        close_i = 1'b0;
        chk("t4_cnt0", 32'(cnt0), 1);
        chk("t4_cnt1", 32'(cnt1), 0);
        chk("t4_state", 32'(state_o), 2);
        chk("t4_pend", 32'(pending_o), 0);
        chk("t4_valid", 32'(winner_valid), 1);

        // tie resolution then clear
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        open_sess();
        repeat (2) pulse(4'b1111);
        repeat (3) pulse(4'b0111);
        repeat (4) pulse(4'b0110);
        chk("t5_cnt1", 32'(cnt1), 9);
        chk("t5_cnt3", 32'(cnt3), 2);
        close_i = 1'b1;
        cyc(1);
        close_i = 1'b0;
        chk("t5_winner", 32'(winner), 1);
        chk("t5_tie", 32'(tie), 1);
        chk("t5_valid", 32'(winner_valid), 1);
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        chk("t5_state", 32'(state_o), 0);
        chk("t5_cnt2", 32'(cnt2), 0);
        chk("t5_valid_off", 32'(winner_valid), 0);

        // display scan in OPEN, then blink in CLOSED
        open_sess();
        pulse(4'b1111);
        repeat (2) pulse(4'b0111);
        repeat (4) pulse(4'b0110);
        repeat (3) pulse(4'b0100);
        wait_dig(4'b1000, "t6_wait_d3");
        wait_dig(4'b0001, "t6_wait_d0");
        for (int d = 0; d < 4; d++) begin
            for (int j = 0; j < SCAN_DIV; j++) begin
                chk("t6_dig_en", 32'(dig_en), 1 << d);
                chk("t6_code", 32'(code), scan_exp[d]);
                cyc(1);
            end
        end
        close_i = 1'b1;
        cyc(1);
        close_i = 1'b0;
        chk("t7_winner", 32'(winner), 2);
        wait_dig(4'b0010, "t7_wait_d1");
        wait_dig(4'b0100, "t7_wait_d2");
        for (int j = 0; j < SCAN_DIV; j++) begin
            chk("t7_blink", 32'(code), (j < SCAN_DIV / 2) ? 15 : 10);
            cyc(1);
        end

        // reset while grants are in flight
        clear_i = 1'b1;
        cyc(1);
        clear_i = 1'b0;
        open_sess();
        vote = 4'b1111;
        cyc(1);
        vote = 4'b0000;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("t8_state", 32'(state_o), 0);
        chk("t8_cnt0", 32'(cnt0), 0);
        chk("t8_pend", 32'(pending_o), 0);
        chk("t8_dig_en", 32'(dig_en), 1);
        chk("t8_code", 32'(code), 0);
        chk("t8_valid", 32'(winner_valid), 0);
        reset = 1'b0;

        // randomized session traffic
        for (int n = 0; n < 4000; n++) begin
            reset   = ($urandom_range(0, 699) == 0);
            open_i  = ($urandom_range(0, 7) == 0);
            close_i = ($urandom_range(0, 39) == 0);
            clear_i = ($urandom_range(0, 29) == 0);
            vote    = 4'($urandom) & 4'($urandom);
            cyc(1);
        end
        reset   = 1'b0;
        open_i  = 1'b0;
        close_i = 1'b0;
        clear_i = 1'b0;
        vote    = 4'b0000;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
